// File: rtl/pulse_burst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pulse_burst_sequencer                                      |
// | Description : Turns a programmed configuration into bursts of pulses.    |
// |               Each burst has cfg_count pulses of cfg_period cycles and   |
// |               cfg_width high time. cfg_bursts bursts are separated by     |
// |               cfg_gap low cycles. The sequence can be aborted at any time.|
// |               The configuration is captured when the sequence starts.    |
// | Option      : TRIG_SYNC_EN - start is an asynchronous trigger level,     |
// |               passed through a 2-flop synchronizer and a registered      |
// |               rising-edge detect (3 extra cycles of latency).            |
// | Ports       : clk, rst          clock, synchronous active-high reset     |
// |               start, stop       begin / abort sequence                   |
// |               cfg_period/width/gap (CW), cfg_count/bursts (NW)           |
// |               pulse_out         registered pulse output                  |
// |               busy, done, cfg_err  status flags and strobes              |
// |               pulse_idx, burst_idx  0-based progress indices             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pulse_burst_sequencer #(
    parameter int CW = 32,
    parameter int NW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_width,
    input  logic [NW-1:0] cfg_count,
    input  logic [NW-1:0] cfg_bursts,
    input  logic [CW-1:0] cfg_gap,
    output logic          pulse_out,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic [NW-1:0] pulse_idx,
    output logic [NW-1:0] burst_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] C_ONE_CW = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0] C_ONE_NW = {{(NW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [CW-1:0] ph_q, ph_d;          // cycle position inside the current period
    logic [CW-1:0] gcnt_q, gcnt_d;      // cycle position inside the inter-burst gap
    logic [NW-1:0] pidx_q, pidx_d;
    logic [NW-1:0] bidx_q, bidx_d;
    logic [CW-1:0] per_q, per_d;        // shadow configuration
    logic [CW-1:0] wid_q, wid_d;        // already clamped
    logic [NW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] bur_q, bur_d;
    logic [CW-1:0] gap_q, gap_d;
    logic          pulse_q, pulse_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          w_start;
    logic          w_cap;
    logic          w_cfg_bad;
    logic [CW-1:0] w_wid_clamp;
    logic [CW-1:0] w_wid_use;

`ifdef TRIG_SYNC_EN
    logic trig_s1_q, trig_s2_q, trig_s3_q, trig_edge_q;

    // Two synchronizer flops, a delay flop for edge detection, and a
    // registered edge so a held trigger yields exactly one start.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_s1_q   <= 1'b0;
            trig_s2_q   <= 1'b0;
            trig_s3_q   <= 1'b0;
            trig_edge_q <= 1'b0;
        end else begin
            trig_s1_q   <= start;
            trig_s2_q   <= trig_s1_q;
            trig_s3_q   <= trig_s2_q;
            trig_edge_q <= trig_s2_q & ~trig_s3_q;
        end
    end

    assign w_start = trig_edge_q;
`else
    assign w_start = start;
`endif

    // Keep at least one low cycle per period; period==1 forces width 0.
    assign w_wid_clamp = (cfg_width >= cfg_period) ? (cfg_period - C_ONE_CW) : cfg_width;
    assign w_cfg_bad   = (cfg_period == '0) || (cfg_count == '0) || (cfg_bursts == '0);

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        gcnt_d  = gcnt_q;
        pidx_d  = pidx_q;
        bidx_d  = bidx_q;
        err_d   = 1'b0;
        w_cap   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // stop in the same cycle suppresses the start
                if (w_start && !stop) begin
                    w_cap  = 1'b1;
                    ph_d   = '0;
                    pidx_d = '0;
                    bidx_d = '0;
                    if (w_cfg_bad) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_PULSE;
                    end
                end
            end
            S_PULSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    ph_d    = '0;
                    pidx_d  = '0;
                    bidx_d  = '0;
                end else if (ph_q == per_q - C_ONE_CW) begin
                    ph_d = '0;
                    if (pidx_q == cnt_q - C_ONE_NW) begin
                        if (bidx_q == bur_q - C_ONE_NW) begin
                            state_d = S_DONE;
                            pidx_d  = '0;
                            bidx_d  = '0;
                        end else if (gap_q != '0) begin
                            state_d = S_GAP;
                            gcnt_d  = '0;
                        end else begin
                            pidx_d = '0;
                            bidx_d = bidx_q + C_ONE_NW;
                        end
                    end else begin
                        pidx_d = pidx_q + C_ONE_NW;
                    end
                end else begin
                    ph_d = ph_q + C_ONE_CW;
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                    ph_d    = '0;
                    pidx_d  = '0;
                    bidx_d  = '0;
                end else if (gcnt_q == gap_q - C_ONE_CW) begin
                    state_d = S_PULSE;
                    ph_d    = '0;
                    pidx_d  = '0;
                    bidx_d  = bidx_q + C_ONE_NW;
                end else begin
                    gcnt_d = gcnt_q + C_ONE_CW;
                end
            end
            default: begin  // S_DONE: one cycle, start ignored
                state_d = S_IDLE;
            end
        endcase

        per_d = w_cap ? cfg_period  : per_q;
        wid_d = w_cap ? w_wid_clamp : wid_q;
        cnt_d = w_cap ? cfg_count   : cnt_q;
        bur_d = w_cap ? cfg_bursts  : bur_q;
        gap_d = w_cap ? cfg_gap     : gap_q;

        // Output flops are loaded from next-state so they align with the state.
        w_wid_use = w_cap ? w_wid_clamp : wid_q;
        pulse_d   = (state_d == S_PULSE) && (ph_d < w_wid_use);
        busy_d    = (state_d == S_PULSE) || (state_d == S_GAP);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            gcnt_q  <= '0;
            pidx_q  <= '0;
            bidx_q  <= '0;
            per_q   <= '0;
            wid_q   <= '0;
            cnt_q   <= '0;
            bur_q   <= '0;
            gap_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            gcnt_q  <= gcnt_d;
            pidx_q  <= pidx_d;
            bidx_q  <= bidx_d;
            per_q   <= per_d;
            wid_q   <= wid_d;
            cnt_q   <= cnt_d;
            bur_q   <= bur_d;
            gap_q   <= gap_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = err_q;
    assign pulse_idx = pidx_q;
    assign burst_idx = bidx_q;

endmodule
`default_nettype wire

// File: doc/pulse_burst_sequencer.md
Name: pulse_burst_sequencer

Overview:
Sequences the laser pulse divider output into programmed bursts: N pulses of fixed period/width per burst, M bursts, with a programmable idle gap between bursts. It sits between the host configuration registers and the pulse output pin. It replaces free-running divider output with an armed, counted, abortable pulse train. The configuration is captured on start, so host writes during a run have no effect.

Parameters:
CW, 32, width of period/width/gap counters (clock cycles)
NW, 16, width of pulse-count and burst-count fields

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  begin sequence (single-cycle; see TRIG_SYNC_EN)
stop  in  1  synchronous abort
cfg_period  in  CW  pulse period in cycles
cfg_width  in  CW  pulse high time in cycles
cfg_count  in  NW  pulses per burst
cfg_bursts  in  NW  number of bursts
cfg_gap  in  CW  low cycles between bursts
pulse_out  out  1  registered pulse output
busy  out  1  sequence in progress
done  out  1  one-cycle completion strobe
cfg_err  out  1  one-cycle strobe: config rejected
pulse_idx  out  NW  current pulse index in burst, 0-based
burst_idx  out  NW  current burst index, 0-based

Behaviour:
- One clock domain; reset is synchronous and active-high; clock port clk, reset port rst.
- Reset: all outputs 0, state IDLE, all counters 0.
- States: IDLE, PULSE, GAP, DONE.
- IDLE, start=1 at cycle t: shadow-capture all cfg_* fields.
  - If cfg_period==0, cfg_count==0 or cfg_bursts==0: at t+1, done=1 and cfg_err=1 for one cycle; no pulses; return to IDLE.
  - Otherwise enter PULSE at t+1 with busy=1 and pulse_idx=burst_idx=0.
- Width clamp: effective width = min(cfg_width, cfg_period-1). At least one low cycle per period unless period==1; with period==1, width is forced to 0.
- width==0: pulse_out stays low, but periods and indices still advance.
- PULSE: each period lasts cfg_period cycles.
  - pulse_out=1 for the first effective-width cycles of each period, 0 for the rest.
  - pulse_out is registered: the first high cycle is t+1.
  - pulse_idx increments on the first cycle of each new period.
- End of last pulse of a burst:
  - If more bursts remain and cfg_gap>0: GAP for cfg_gap cycles with pulse_out=0, then PULSE with pulse_idx=0 and burst_idx+1.
  - If more bursts remain and cfg_gap==0: the next burst starts on the next cycle with no gap.
- After the last period of the last burst: DONE for one cycle (done=1, busy=0, pulse_out=0), then IDLE.
- busy is 1 in PULSE and GAP only.
- start is ignored in any state other than IDLE, including DONE.
- stop=1 in PULSE or GAP:
  - Next cycle: state IDLE, pulse_out=0, busy=0.
  - done is not asserted; indices are cleared.
- stop=1 in IDLE or DONE: no effect, except stop together with start in IDLE suppresses the start.
- rst has priority over stop and start; reset mid-run returns all outputs to 0 on the next cycle.
- Counters are compared with full CW/NW width. There is no wrap: cfg values up to all-ones are legal, and counts reach cfg-1 before rollover.

Optional Feature:
TRIG_SYNC_EN.
- Defined: start is treated as an asynchronous external trigger level. It passes through a 2-flop synchronizer plus rising-edge detect.
  - The effective start is the detected edge, adding 3 cycles latency (first pulse at t+4 from the input edge).
  - A held-high trigger starts only once.
- Undefined: start is a synchronous single-cycle strobe used directly, with no added latency.

Test Plan:
1. period=5, width=2, count=3, bursts=1, start at t -> pulse_out high at t+1,t+2,t+6,t+7,t+11,t+12; busy t+1..t+15; done at t+16 only.
2. period=4, width=1, count=2, bursts=2, gap=3 -> pulses at t+1,t+5,t+12,t+16; pulse_out low t+9..t+11; burst_idx=1 from t+12; done at t+20.
3. period=3, width=5, count=2, bursts=1 -> clamped: high t+1,t+2,t+4,t+5; low t+3,t+6; done t+7.
4. count=0 (or period=0 or bursts=0), start -> done=1 and cfg_err=1 at t+1; pulse_out never high; busy never high.
5. Case-1 config with stop at t+7 -> pulse_out=0, busy=0, state IDLE at t+8; done never asserted. Second start at t+3 is ignored. Changing cfg_period at t+2 does not alter the run.
6. rst asserted at t+6 during case 1 -> all outputs 0 at t+7. With TRIG_SYNC_EN, a trigger held high 20 cycles gives exactly one sequence, first pulse 4 cycles after the edge.
